// File: rtl/reg_station_ooo.sv
// Age-ordered out-of-order reservation station: multi-lane dispatch, CDB wakeup, oldest-ready select.
// Optional RS_STALL_CNT_EN adds a saturating dispatch-stall counter output (stall_cnt).
module reg_station_ooo #(
  parameter  int SIZE       = 32,
  parameter  int REG_NUM    = 8,
  parameter  int ALUOP_BITS = 3,
  parameter  int INPUT_ROWS = 2,
  parameter  int RS_ENTRIES = 8,
  parameter  int CDB_WIDTH  = 2,
  localparam int TAG_BITS   = $clog2(REG_NUM),
  localparam int OCC_BITS   = $clog2(RS_ENTRIES + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [INPUT_ROWS-1:0]                 new_valid,
  input  logic [INPUT_ROWS-1:0][ALUOP_BITS-1:0] new_ALUOp,
  input  logic [INPUT_ROWS-1:0][TAG_BITS-1:0]   new_src_tag1,
  input  logic [INPUT_ROWS-1:0][TAG_BITS-1:0]   new_src_tag2,
  input  logic [INPUT_ROWS-1:0]                 new_src_rdy1,
  input  logic [INPUT_ROWS-1:0]                 new_src_rdy2,
  input  logic [INPUT_ROWS-1:0][SIZE-1:0]       new_src_val1,
  input  logic [INPUT_ROWS-1:0][SIZE-1:0]       new_src_val2,
  input  logic [INPUT_ROWS-1:0]                 new_use_imm,
  input  logic [INPUT_ROWS-1:0][SIZE-1:0]       new_imm,
  input  logic [INPUT_ROWS-1:0][TAG_BITS-1:0]   new_dest_tag,
  output logic                                  new_ready,
  input  logic [CDB_WIDTH-1:0]                  cdb_valid,
  input  logic [CDB_WIDTH-1:0][TAG_BITS-1:0]    cdb_tag,
  input  logic [CDB_WIDTH-1:0][SIZE-1:0]        cdb_val,
  output logic                                  issue_valid,
  input  logic                                  issue_ready,
  output logic [ALUOP_BITS-1:0]                 issue_ALUOp,
  output logic [SIZE-1:0]                       issue_op1,
  output logic [SIZE-1:0]                       issue_op2,
  output logic [TAG_BITS-1:0]                   issue_dest_tag,
  output logic [OCC_BITS-1:0]                   occupancy
`ifdef RS_STALL_CNT_EN
  ,
  output logic [31:0]                           stall_cnt
`endif
);

  localparam int SEL_BITS = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1;

  typedef struct packed {
    logic                  valid;
    logic [ALUOP_BITS-1:0] op;
    logic [TAG_BITS-1:0]   tag1;
    logic [TAG_BITS-1:0]   tag2;
    logic                  rdy1;
    logic                  rdy2;
    logic [SIZE-1:0]       val1;
    logic [SIZE-1:0]       val2;
    logic [TAG_BITS-1:0]   dest;
  } entry_t;

  entry_t                r_ent   [RS_ENTRIES];
  logic [OCC_BITS-1:0]   r_occupancy;
  entry_t                w_woke  [RS_ENTRIES+1];
  entry_t                w_next  [RS_ENTRIES];
  entry_t                w_lane;
  logic                  w_found;
  logic [SEL_BITS-1:0]   w_sel;
  logic                  w_fire;
  logic                  w_dispatch;
  logic [OCC_BITS-1:0]   w_occ_next;
  int                    w_pos;
  int                    w_cnt;

  // Capture matching broadcasts; scanning high-to-low lets the lowest CDB lane win.
  function automatic entry_t wake_entry(input entry_t e,
                                        input logic [CDB_WIDTH-1:0] v,
                                        input logic [CDB_WIDTH-1:0][TAG_BITS-1:0] t,
                                        input logic [CDB_WIDTH-1:0][SIZE-1:0] d);
    entry_t r;
    logic   m1;
    logic   m2;
    r = e;
    for (int c = CDB_WIDTH - 1; c >= 0; c--) begin
      m1     = e.valid & ~e.rdy1 & v[c] & (t[c] == e.tag1);
      m2     = e.valid & ~e.rdy2 & v[c] & (t[c] == e.tag2);
      r.rdy1 = r.rdy1 | m1;
      r.rdy2 = r.rdy2 | m2;
      r.val1 = m1 ? d[c] : r.val1;
      r.val2 = m2 ? d[c] : r.val2;
    end
    return r;
  endfunction

  assign new_ready = ((RS_ENTRIES - int'(r_occupancy)) >= INPUT_ROWS);
  assign occupancy = r_occupancy;

  // Oldest fully-ready entry drives the issue port.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (!w_found && r_ent[i].valid && r_ent[i].rdy1 && r_ent[i].rdy2) begin
        w_found = 1'b1;
        w_sel   = SEL_BITS'(i);
      end else begin
        w_found = w_found;
      end
    end
    issue_valid = w_found;
    if (w_found) begin
      issue_ALUOp    = r_ent[w_sel].op;
      issue_op1      = r_ent[w_sel].val1;
      issue_op2      = r_ent[w_sel].val2;
      issue_dest_tag = r_ent[w_sel].dest;
    end else begin
      issue_ALUOp    = '0;
      issue_op1      = '0;
      issue_op2      = '0;
      issue_dest_tag = '0;
    end
  end

  // Next entry array: wakeup, compaction over the issued slot, then tail append.
  always_comb begin
    w_fire     = issue_valid & issue_ready;
    w_dispatch = new_ready & ~flush;
    w_lane     = '0;
    w_cnt      = 0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      w_woke[i] = wake_entry(r_ent[i], cdb_valid, cdb_tag, cdb_val);
    end
    w_woke[RS_ENTRIES] = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      w_next[i] = (w_fire && (i >= int'(w_sel))) ? w_woke[i+1] : w_woke[i];
    end
    w_pos = int'(r_occupancy) - (w_fire ? 1 : 0);
    for (int l = 0; l < INPUT_ROWS; l++) begin
      if (w_dispatch && new_valid[l]) begin
        w_lane.valid = 1'b1;
        w_lane.op    = new_ALUOp[l];
        w_lane.tag1  = new_src_tag1[l];
        w_lane.rdy1  = new_src_rdy1[l];
        w_lane.val1  = new_src_val1[l];
        w_lane.tag2  = new_use_imm[l] ? '0 : new_src_tag2[l];
        w_lane.rdy2  = new_use_imm[l] | new_src_rdy2[l];
        w_lane.val2  = new_use_imm[l] ? new_imm[l] : new_src_val2[l];
        w_lane.dest  = new_dest_tag[l];
        w_lane       = wake_entry(w_lane, cdb_valid, cdb_tag, cdb_val);
        for (int i = 0; i < RS_ENTRIES; i++) begin
          w_next[i] = (i == w_pos) ? w_lane : w_next[i];
        end
        w_pos = w_pos + 1;
        w_cnt = w_cnt + 1;
      end else begin
        w_pos = w_pos;
      end
    end
    w_occ_next = OCC_BITS'(int'(r_occupancy) + w_cnt - (w_fire ? 1 : 0));
  end

  // Entry array and occupancy state; reset outranks flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
        r_ent[i] <= '0;
      end
      r_occupancy <= '0;
    end else begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
        r_ent[i] <= w_next[i];
      end
      r_occupancy <= w_occ_next;
    end
  end

`ifdef RS_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  assign stall_cnt = r_stall_cnt;

  // Saturating count of refused dispatch cycles; flush leaves it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 32'd0;
    end else if ((|new_valid) && !new_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_reg_station_ooo.sv
// Randomized plus directed bench for reg_station_ooo against a queue-based age-ordered model.
module tb_reg_station_ooo;
  localparam int SIZE = 32, AB = 3, IR = 2, RS = 8, CW = 2, TB = 3, OB = 4;

  logic clk = 1'b0;
  logic rst, flush, issue_ready, new_ready, issue_valid;
  logic [IR-1:0]         new_valid, new_src_rdy1, new_src_rdy2, new_use_imm;
  logic [IR-1:0][AB-1:0] new_ALUOp;
  logic [IR-1:0][TB-1:0] new_src_tag1, new_src_tag2, new_dest_tag;
  logic [IR-1:0][SIZE-1:0] new_src_val1, new_src_val2, new_imm;
  logic [CW-1:0]         cdb_valid;
  logic [CW-1:0][TB-1:0] cdb_tag;
  logic [CW-1:0][SIZE-1:0] cdb_val;
  logic [AB-1:0]   issue_ALUOp;
  logic [SIZE-1:0] issue_op1, issue_op2;
  logic [TB-1:0]   issue_dest_tag;
  logic [OB-1:0]   occupancy;
`ifdef RS_STALL_CNT_EN
  logic [31:0] stall_cnt;
  longint m_stall = 0;
`endif

  reg_station_ooo dut (
    .clk(clk), .rst(rst), .flush(flush), .new_valid(new_valid), .new_ALUOp(new_ALUOp),
    .new_src_tag1(new_src_tag1), .new_src_tag2(new_src_tag2),
    .new_src_rdy1(new_src_rdy1), .new_src_rdy2(new_src_rdy2),
    .new_src_val1(new_src_val1), .new_src_val2(new_src_val2),
    .new_use_imm(new_use_imm), .new_imm(new_imm), .new_dest_tag(new_dest_tag),
    .new_ready(new_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_ALUOp(issue_ALUOp),
    .issue_op1(issue_op1), .issue_op2(issue_op2), .issue_dest_tag(issue_dest_tag),
    .occupancy(occupancy)
`ifdef RS_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [AB-1:0] op;
    logic [TB-1:0] t1, t2, dest;
    bit r1, r2;
    logic [SIZE-1:0] v1, v2;
  } m_t;
  m_t q[$];

  function automatic m_t wake(input m_t e);
    m_t r = e;
    bit h1 = 0, h2 = 0;
    for (int c = 0; c < CW; c++) begin
      if (!e.r1 && !h1 && cdb_valid[c] && cdb_tag[c] == e.t1) begin r.r1 = 1; r.v1 = cdb_val[c]; h1 = 1; end
      if (!e.r2 && !h2 && cdb_valid[c] && cdb_tag[c] == e.t2) begin r.r2 = 1; r.v2 = cdb_val[c]; h2 = 1; end
    end
    return r;
  endfunction

  function automatic int find_sel();
    foreach (q[i]) if (q[i].r1 && q[i].r2) return i;
    return -1;
  endfunction

  task automatic check_outputs();
    int sel = find_sel();
    check_val("new_ready", new_ready, (RS - q.size()) >= IR);
    check_val("occupancy", occupancy, q.size());
    check_val("issue_valid", issue_valid, sel >= 0);
    if (sel >= 0) begin
      check_val("issue_ALUOp", issue_ALUOp, q[sel].op);
      check_val("issue_op1", issue_op1, q[sel].v1);
      check_val("issue_op2", issue_op2, q[sel].v2);
      check_val("issue_dest", issue_dest_tag, q[sel].dest);
    end
`ifdef RS_STALL_CNT_EN
    check_val("stall_cnt", stall_cnt, m_stall);
`endif
  endtask

  task automatic model_update();
    bit ok = (RS - q.size()) >= IR;
    int sel = find_sel();
    m_t e;
`ifdef RS_STALL_CNT_EN
    if (rst) m_stall = 0;
    else if (|new_valid && !ok && m_stall != 64'hFFFF_FFFF) m_stall++;
`endif
    if (rst || flush) begin
      q.delete();
    end else begin
      if (sel >= 0 && issue_ready) q.delete(sel);
      foreach (q[i]) q[i] = wake(q[i]);
      if (ok) begin
        for (int l = 0; l < IR; l++) begin
          if (new_valid[l]) begin
            e.op = new_ALUOp[l]; e.dest = new_dest_tag[l];
            e.t1 = new_src_tag1[l]; e.r1 = new_src_rdy1[l]; e.v1 = new_src_val1[l];
            e.t2 = new_use_imm[l] ? '0 : new_src_tag2[l];
            e.r2 = new_use_imm[l] | new_src_rdy2[l];
            e.v2 = new_use_imm[l] ? new_imm[l] : new_src_val2[l];
            q.push_back(wake(e));
          end
        end
      end
    end
  endtask

  task automatic step();
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst = 0; flush = 0; new_valid = '0; new_ALUOp = '0; new_src_tag1 = '0; new_src_tag2 = '0;
    new_src_rdy1 = '0; new_src_rdy2 = '0; new_src_val1 = '0; new_src_val2 = '0;
    new_use_imm = '0; new_imm = '0; new_dest_tag = '0; cdb_valid = '0; cdb_tag = '0; cdb_val = '0;
  endtask

  task automatic set_lane(input int l, input logic [AB-1:0] op, input logic [TB-1:0] t1, input bit r1,
                          input logic [SIZE-1:0] v1, input logic [TB-1:0] t2, input bit r2,
                          input logic [SIZE-1:0] v2, input bit ui, input logic [SIZE-1:0] imm,
                          input logic [TB-1:0] dest);
    new_valid[l] = 1; new_ALUOp[l] = op; new_src_tag1[l] = t1; new_src_rdy1[l] = r1;
    new_src_val1[l] = v1; new_src_tag2[l] = t2; new_src_rdy2[l] = r2; new_src_val2[l] = v2;
    new_use_imm[l] = ui; new_imm[l] = imm; new_dest_tag[l] = dest;
  endtask

  task automatic do_reset();
    clear_inputs(); rst = 1;
    @(posedge clk); #1;
    q.delete();
`ifdef RS_STALL_CNT_EN
    m_stall = 0;
`endif
    rst = 0;
    check_val("rst_op1", issue_op1, 0);
    check_val("rst_op2", issue_op2, 0);
    check_val("rst_aluop", issue_ALUOp, 0);
    check_val("rst_dest", issue_dest_tag, 0);
  endtask

  initial begin
    issue_ready = 1;
    do_reset();
    // ready ADD issues the next cycle
    set_lane(0, 3'd1, 3'd0, 1, 32'd5, 3'd0, 1, 32'd7, 0, 32'd0, 3'd3);
    step(); clear_inputs(); step(); step();
    // wait on tag 2 with immediate operand
    set_lane(0, 3'd2, 3'd2, 0, 32'd0, 3'd0, 0, 32'd0, 1, 32'd10, 3'd5);
    step(); clear_inputs(); step();
    cdb_valid = 2'b01; cdb_tag[0] = 3'd2; cdb_val[0] = 32'd40;
    step(); clear_inputs(); step(); step();
    // same-cycle dispatch bypass on cdb lane 1
    set_lane(0, 3'd3, 3'd4, 0, 32'd0, 3'd0, 1, 32'd1, 0, 32'd0, 3'd1);
    set_lane(1, 3'd4, 3'd4, 0, 32'd0, 3'd0, 1, 32'd2, 0, 32'd0, 3'd2);
    cdb_valid = 2'b10; cdb_tag[1] = 3'd4; cdb_val[1] = 32'd9;
    step(); clear_inputs(); repeat (3) step();
    // fill with waiting entries, then keep pushing
    issue_ready = 0;
    repeat (7) begin
      set_lane(0, 3'd1, 3'd7, 0, 32'd0, 3'd7, 0, 32'd0, 0, 32'd0, 3'd6);
      set_lane(1, 3'd1, 3'd7, 0, 32'd0, 3'd7, 0, 32'd0, 0, 32'd0, 3'd6);
      step();
    end
    clear_inputs(); flush = 1; step(); clear_inputs();
    // two ready entries held then drained in age order
    set_lane(0, 3'd5, 3'd0, 1, 32'd11, 3'd0, 1, 32'd12, 0, 32'd0, 3'd1);
    set_lane(1, 3'd5, 3'd6, 0, 32'd0, 3'd0, 1, 32'd0, 0, 32'd0, 3'd2);
    step();
    set_lane(0, 3'd6, 3'd0, 1, 32'd21, 3'd0, 1, 32'd22, 0, 32'd0, 3'd3);
    set_lane(1, 3'd6, 3'd6, 0, 32'd0, 3'd0, 1, 32'd0, 0, 32'd0, 3'd4);
    step(); clear_inputs(); repeat (3) step();
    issue_ready = 1; repeat (3) step();
    // flush with same-cycle dispatch and issue
    set_lane(0, 3'd2, 3'd0, 1, 32'd1, 3'd0, 1, 32'd2, 0, 32'd0, 3'd1);
    set_lane(1, 3'd2, 3'd5, 0, 32'd0, 3'd5, 0, 32'd0, 0, 32'd0, 3'd1);
    step(); step(); step();
    flush = 1; step(); clear_inputs(); step();
    // reset while a wakeup is in flight
    set_lane(0, 3'd2, 3'd3, 0, 32'd0, 3'd0, 1, 32'd2, 0, 32'd0, 3'd1);
    step(); clear_inputs();
    cdb_valid = 2'b01; cdb_tag[0] = 3'd3; cdb_val[0] = 32'd77; rst = 1;
    step();
    check_val("rst_mid_op1", issue_op1, 0);
    clear_inputs(); step();
    // randomized phase
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rst = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 59) == 0);
      issue_ready = (cyc % 300 < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      new_valid = IR'($urandom);
      for (int l = 0; l < IR; l++) begin
        new_ALUOp[l] = AB'($urandom); new_dest_tag[l] = TB'($urandom);
        new_src_tag1[l] = TB'($urandom); new_src_tag2[l] = TB'($urandom);
        new_src_rdy1[l] = $urandom_range(0, 1); new_src_rdy2[l] = $urandom_range(0, 1);
        new_src_val1[l] = $urandom; new_src_val2[l] = $urandom;
        new_use_imm[l] = ($urandom_range(0, 3) == 0); new_imm[l] = $urandom;
      end
      for (int c = 0; c < CW; c++) begin
        cdb_valid[c] = $urandom_range(0, 1); cdb_tag[c] = TB'($urandom); cdb_val[c] = $urandom;
      end
      step();
    end
    clear_inputs(); step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
